// File: rtl/spi_slave_engine.sv
`default_nettype none
// ============================================================================
//  Module  : spi_slave_engine
//  Brief   : SPI responder for all CPOL/CPHA modes; oversamples the pins in the
//            clk domain, MSB-first, back-to-back words within one CS_n window.
//  Revision: 1.0  initial release
// ============================================================================
module spi_slave_engine #(
  parameter int DATA_WIDTH    = 8,
  parameter int COUNTER_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  CPOL,
  input  logic                  CPHA,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic                  tx_underrun,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy
);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  localparam logic [COUNTER_WIDTH-1:0] c_last_bit = COUNTER_WIDTH'(DATA_WIDTH - 1);
  localparam logic [COUNTER_WIDTH-1:0] c_cnt_one  = COUNTER_WIDTH'(1);

  state_t                   r_state;
  logic                     r_sclk_meta, r_sclk_sync, r_sclk_prev;
  logic                     r_cs_meta, r_cs_sync;
  logic                     r_mosi_meta, r_mosi_sync;
  logic                     r_cpol, r_cpha;
  logic [COUNTER_WIDTH-1:0] r_bit_cnt;
  logic [DATA_WIDTH-2:0]    r_rx_shift;
  logic [DATA_WIDTH-1:0]    r_tx_shift;
  logic [DATA_WIDTH-1:0]    r_tx_buf;
  logic                     r_tx_ready;
  logic                     r_tx_underrun;
  logic [DATA_WIDTH-1:0]    r_rx_data;
  logic                     r_rx_valid;

  logic w_rise, w_fall, w_lead, w_trail, w_sample, w_shift;
  logic w_active, w_last_sample, w_reload, w_accept;

  assign w_rise        = r_sclk_sync & ~r_sclk_prev;
  assign w_fall        = ~r_sclk_sync & r_sclk_prev;
  assign w_lead        = r_cpol ? w_fall : w_rise;
  assign w_trail       = r_cpol ? w_rise : w_fall;
  assign w_sample      = r_cpha ? w_trail : w_lead;
  assign w_shift       = r_cpha ? w_lead : w_trail;
  assign w_active      = (r_state == S_ACTIVE) & ~r_cs_sync;
  assign w_last_sample = w_sample & (r_bit_cnt == c_last_bit);

  // A zero count on a CPHA=0 shift edge can only follow a completed word.
  assign w_reload = ((r_state == S_IDLE) & ~r_cs_sync)
                  | (w_active & ~r_cpha & w_shift & (r_bit_cnt == '0))
                  | (w_active &  r_cpha & w_last_sample);
  assign w_accept = tx_load & (r_tx_ready | w_reload);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_sclk_meta   <= 1'b0;
      r_sclk_sync   <= 1'b0;
      r_sclk_prev   <= 1'b0;
      r_cs_meta     <= 1'b1;
      r_cs_sync     <= 1'b1;
      r_mosi_meta   <= 1'b0;
      r_mosi_sync   <= 1'b0;
      r_cpol        <= 1'b0;
      r_cpha        <= 1'b0;
      r_bit_cnt     <= '0;
      r_rx_shift    <= '0;
      r_tx_shift    <= '0;
      r_tx_buf      <= '0;
      r_tx_ready    <= 1'b1;
      r_tx_underrun <= 1'b0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
    end else begin
      r_sclk_meta   <= sclk;
      r_sclk_sync   <= r_sclk_meta;
      r_sclk_prev   <= r_sclk_sync;
      r_cs_meta     <= cs_n;
      r_cs_sync     <= r_cs_meta;
      r_mosi_meta   <= mosi;
      r_mosi_sync   <= r_mosi_meta;
      r_rx_valid    <= 1'b0;
      r_tx_underrun <= 1'b0;

      if (w_reload) begin
        r_tx_shift    <= r_tx_ready ? '0 : r_tx_buf;
        r_tx_underrun <= r_tx_ready;
        r_tx_ready    <= 1'b1;
      end
      // A load coinciding with a reload refills the buffer just emptied.
      if (w_accept) begin
        r_tx_buf   <= tx_data;
        r_tx_ready <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (!r_cs_sync) begin
            r_state <= S_ACTIVE;
            r_cpol  <= CPOL;
            r_cpha  <= CPHA;
          end
        end
        S_ACTIVE: begin
          if (r_cs_sync) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= '0;
            r_tx_shift <= '0;
          end else if (w_sample) begin
            r_rx_shift <= {r_rx_shift[DATA_WIDTH-3:0], r_mosi_sync};
            if (w_last_sample) begin
              r_rx_data  <= {r_rx_shift, r_mosi_sync};
              r_rx_valid <= 1'b1;
              r_bit_cnt  <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + c_cnt_one;
            end
          end else if (w_shift && (r_bit_cnt != '0)) begin
            r_tx_shift <= r_tx_shift << 1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign miso        = r_tx_shift[DATA_WIDTH-1];
  assign miso_oe     = (r_state == S_ACTIVE);
  assign busy        = (r_state == S_ACTIVE);
  assign tx_ready    = r_tx_ready;
  assign tx_underrun = r_tx_underrun;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_engine.sv
`default_nettype none
// ============================================================================
//  Module  : tb_spi_slave_engine
//  Brief   : Directed and randomized SPI master transfers against a
//            word-level model of the responder's buffer and data flow.
//  Revision: 1.0  initial release
// ============================================================================
module tb_spi_slave_engine;

  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst, CPOL, CPHA, sclk, cs_n, mosi, tx_load;
  logic [7:0] tx_data;
  logic       miso, miso_oe, tx_ready, tx_underrun, rx_valid, busy;
  logic [7:0] rx_data;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] rx_log[$];
  int         underrun_total = 0;

  logic       m_buf_full;
  logic [7:0] m_buf_val;
  logic [7:0] m_rx;
  logic [7:0] mosi_w[4];
  logic [7:0] next_w[4];

  spi_slave_engine #(.DATA_WIDTH(8), .COUNTER_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .CPOL(CPOL), .CPHA(CPHA), .sclk(sclk), .cs_n(cs_n),
    .mosi(mosi), .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data),
    .tx_load(tx_load), .tx_ready(tx_ready), .tx_underrun(tx_underrun),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && rx_valid) rx_log.push_back(rx_data);
    if (!rst && tx_underrun) underrun_total++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input logic [7:0] v);
    tx_data = v;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
    if (!m_buf_full) begin
      m_buf_full = 1'b1;
      m_buf_val  = v;
    end
  endtask

  // Model: each word transmits whatever the buffer held when the word began
  // (zero plus one underrun if empty); every completed word is received.
  task automatic xfer(input logic cpol_i, input logic cpha_i, input int nwords,
                      input int abort_bits, input logic [3:0] load_mask);
    logic [7:0] cur, got;
    logic [7:0] exp_rx[$];
    int nb, rx_base, un_base, exp_un;
    CPOL = cpol_i; CPHA = cpha_i; sclk = cpol_i; cs_n = 1'b1;
    tick(6);
    rx_base = rx_log.size();
    un_base = underrun_total;
    exp_un  = 0;
    cs_n = 1'b0;
    cur = m_buf_full ? m_buf_val : 8'h00;
    if (!m_buf_full) exp_un++;
    m_buf_full = 1'b0;
    tick(2 * H);
    check("busy_active", 32'(busy), 32'd1);
    check("oe_active", 32'(miso_oe), 32'd1);
    for (int w = 0; w < nwords; w++) begin
      nb  = (w == nwords - 1 && abort_bits != 0) ? abort_bits : 8;
      got = 8'h00;
      for (int b = 0; b < nb; b++) begin
        if (cpha_i) sclk = ~cpol_i;
        mosi = mosi_w[w][7-b];
        if (load_mask[w] && b == 2) begin
          load_word(next_w[w]);
          tick(H - 1);
        end else begin
          tick(H);
        end
        got  = {got[6:0], miso};
        sclk = ~sclk;
        tick(H);
        if (!cpha_i) sclk = cpol_i;
      end
      if (nb == 8) begin
        check("miso_word", 32'(got), 32'(cur));
        exp_rx.push_back(mosi_w[w]);
        m_rx = mosi_w[w];
        cur  = m_buf_full ? m_buf_val : 8'h00;
        if (!m_buf_full) exp_un++;
        m_buf_full = 1'b0;
      end
    end
    tick(H);
    cs_n = 1'b1;
    tick(6);
    check("rx_count", 32'(rx_log.size() - rx_base), 32'(exp_rx.size()));
    for (int i = 0; i < exp_rx.size() && rx_base + i < rx_log.size(); i++)
      check("rx_word", 32'(rx_log[rx_base+i]), 32'(exp_rx[i]));
    check("rx_data_held", 32'(rx_data), 32'(m_rx));
    check("underruns", 32'(underrun_total - un_base), 32'(exp_un));
    check("busy_idle", 32'(busy), 32'd0);
    check("oe_idle", 32'(miso_oe), 32'd0);
    check("miso_idle", 32'(miso), 32'd0);
    check("tx_ready", 32'(tx_ready), 32'(!m_buf_full));
  endtask

  initial begin
    logic [1:0] mode;
    rst = 1'b1; CPOL = 1'b0; CPHA = 1'b0; sclk = 1'b0; cs_n = 1'b1;
    mosi = 1'b0; tx_load = 1'b0; tx_data = 8'h00;
    m_buf_full = 1'b0; m_buf_val = 8'h00; m_rx = 8'h00;
    tick(3);
    rst = 1'b0;
    tick(2);
    check("reset_tx_ready", 32'(tx_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_oe", 32'(miso_oe), 32'd0);
    check("reset_miso", 32'(miso), 32'd0);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'd0);

    // Mode 0 single word
    load_word(8'hA5);
    check("tx_ready_after_load", 32'(tx_ready), 32'd0);
    mosi_w[0] = 8'h3C;
    xfer(1'b0, 1'b0, 1, 0, 4'b0000);

    // Mode 3, two words, buffer refilled ahead of each boundary
    load_word(8'h81);
    mosi_w[0] = 8'h12; mosi_w[1] = 8'h34;
    next_w[0] = 8'h7E; next_w[1] = 8'h55;
    xfer(1'b1, 1'b1, 2, 0, 4'b0011);

    // Modes 1 and 2
    load_word(8'hF0); mosi_w[0] = 8'hF0;
    xfer(1'b0, 1'b1, 1, 0, 4'b0000);
    load_word(8'hF0); mosi_w[0] = 8'hF0;
    xfer(1'b1, 1'b0, 1, 0, 4'b0000);

    // Abort after 5 bits, then a full transfer
    load_word(8'h6B); mosi_w[0] = 8'hC7;
    xfer(1'b0, 1'b0, 1, 5, 4'b0000);
    load_word(8'h2D); mosi_w[0] = 8'h9A;
    xfer(1'b0, 1'b0, 1, 0, 4'b0000);

    // Load while full is ignored; second word underruns
    load_word(8'hE1);
    load_word(8'h1E);
    mosi_w[0] = 8'h5A; mosi_w[1] = 8'hA6;
    xfer(1'b0, 1'b0, 2, 0, 4'b0000);

    // Reset in mid-word
    load_word(8'hC3);
    CPOL = 1'b0; CPHA = 1'b0; sclk = 1'b0; cs_n = 1'b0;
    tick(2 * H);
    mosi = 1'b1; tick(H); sclk = 1'b1; tick(H); sclk = 1'b0; tick(H); sclk = 1'b1;
    tick(3);
    rst = 1'b1;
    #1;
    check("rst_mid_oe", 32'(miso_oe), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_mid_miso", 32'(miso), 32'd0);
    check("rst_mid_rx_data", 32'(rx_data), 32'd0);
    cs_n = 1'b1; sclk = 1'b0;
    tick(3);
    rst = 1'b0;
    m_buf_full = 1'b0; m_rx = 8'h00;
    tick(2);
    load_word(8'h4D); mosi_w[0] = 8'hB2;
    xfer(1'b0, 1'b0, 1, 0, 4'b0000);

    // Randomized transfers
    for (int t = 0; t < 8; t++) begin
      logic [3:0] mask;
      int nw;
      mode = 2'($urandom_range(0, 3));
      nw   = $urandom_range(1, 3);
      mask = 4'($urandom);
      for (int w = 0; w < 4; w++) begin
        mosi_w[w] = 8'($urandom);
        next_w[w] = 8'($urandom);
      end
      if ($urandom_range(0, 3) != 0) load_word(8'($urandom));
      xfer(mode[1], mode[0], nw, 0, mask);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
